pma_router: RTL
===============

Name: pma_router

Overview:
- Parametrised successor to the fixed four-chip address decoder in the crossbar.
- Maps a request address to a target region index, a region-relative offset and a permission verdict, using a runtime-programmable region table with per-region lock.
- One registered pipeline stage with valid/ready on both sides; sits between the core bus master and the crossbar target mux.
- Flags unmapped and permission faults and keeps a saturating fault counter.

Parameters:
- NUM_REGIONS, 4, number of table entries (1..16).
- ADDR_W, 64, request address, base and size width.
- IDX_W, $clog2(NUM_REGIONS) (min 1), region index width (derived, not overridable).
- CNT_W, 32, fault counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid&&ready.
- req_addr  in  ADDR_W  absolute address.
- req_op  in  2  0=read, 1=write, 2=fetch, 3=reserved (always faults).
- rsp_valid  out  1  decoded result valid.
- rsp_ready  in  1  downstream accepts result.
- rsp_idx  out  IDX_W  selected region index (0 on fault).
- rsp_addr  out  ADDR_W  req_addr - base of selected region (req_addr unchanged on fault).
- rsp_err  out  1  fault flag.
- rsp_cause  out  2  0=none, 1=unmapped, 2=permission, 3=bad op.
- cfg_we  in  1  table write strobe.
- cfg_idx  in  IDX_W  entry to write.
- cfg_base  in  ADDR_W  new base.
- cfg_size  in  ADDR_W  new size; 0 disables entry.
- cfg_perm  in  3  {X,W,R} permissions.
- cfg_lock  in  1  set lock on entry.
- cfg_err  out  1  registered; 1 for one cycle after a rejected write.
- fault_cnt  out  CNT_W  saturating count of faulting responses.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. All state resets on the rst_n low edge sampled at clk.
- Reset values:
  - rsp_valid=0, rsp_idx=0, rsp_addr=0, rsp_err=0, rsp_cause=0, cfg_err=0, fault_cnt=0, all locks=0.
  - Table entries 0..3 reset to the default map: 0x0/0x1000 RW, 0x1000/0xff000 RX, 0x1000_0000/0x100 RW, 0x8000_0000/0x8000_0000 RWX.
  - Entries 4+ reset to size 0.
- Hit test for entry i: size!=0 && addr>=base && (addr-base)<size. Evaluate in ADDR_W using subtraction only, never base+size, so regions ending at 2^ADDR_W decode correctly.
- Overlap: the lowest hitting index wins.
- Permission check: read needs R, write needs W, fetch needs X.
- Fault priority: bad op > unmapped > permission.
- Pipeline:
  - req_ready = !rsp_valid || rsp_ready.
  - On accept, the decode result is registered and appears next cycle (latency 1). Full throughput: one request per cycle under continuous rsp_ready.
  - While rsp_valid && !rsp_ready, all rsp_* outputs hold stable.
- Table writes:
  - A write to a locked entry is ignored and sets cfg_err next cycle.
  - Otherwise base/size/perm update at the clock edge, and lock ORs in cfg_lock. Locks clear only on reset.
  - A request accepted in the same cycle as a cfg write decodes with the old table; the new entry applies from the next cycle.
- Fault counter: increments when a faulting response is registered (on accept, not on rsp handshake). Saturates at all-ones.
- Reset mid-transfer: any pending rsp is dropped; no response is produced for it.

Decomposition:
- Shared package pma_pkg: op encoding, cause encoding, region entry struct {base, size, perm, lock}, default-map constant array.
  - These replace the existing global ranges table; the current chip enum maps to the default indices.
- Natural sub-module: pma_region_match. Purely combinational per-entry hit/perm test, instantiated NUM_REGIONS times via generate. The priority encode, pipeline register, cfg logic and counter stay in pma_router.

Test Plan:
- Reset defaults: req read 0x1000_0010 -> next cycle rsp_idx=2, rsp_addr=0x10, rsp_err=0. Fetch 0x2000 -> idx=1, addr=0x1000.
- Unmapped: read 0x2000_0000 -> rsp_err=1, cause=1, rsp_addr=0x2000_0000, fault_cnt=1. Write 0x1000 (ROM, no W) -> cause=2, fault_cnt=2.
- Top-of-space: read 0xFFFF_FFFF -> idx=3, addr=0x7FFF_FFFF. Reprogram entry 3 to base 0xFFFF_FFFF_FFFF_F000, size 0x1000; read 0xFFFF_FFFF_FFFF_FFF8 -> idx=3, addr=0xFF8, no wrap fault.
- Backpressure: hold rsp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, rsp fields stable. Release -> back-to-back responses at one per cycle, order preserved.
- Lock and same-cycle update:
  - Write entry 2 with cfg_lock=1, then write entry 2 again -> cfg_err=1 for one cycle, table unchanged.
  - A cfg write to entry 0 in the same cycle as a request to 0x10 -> that response uses the old map.
- Overlap and saturation:
  - Set entry 1 = 0x0/0x10000 -> read 0x500 returns idx=0.
  - Force fault_cnt via CNT_W=4 build with 20 faults -> fault_cnt=15.

Source files
------------

// File: rtl/pma_pkg.sv
// Shared definitions for the physical memory attribute router: op/cause encodings,
// region entry layout and the power-on address map.
package pma_pkg;

    localparam int PMA_MAX_ADDR_W  = 64;
    localparam int PMA_NUM_DEFAULT = 4;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_FETCH = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_UNMAPPED = 2'd1,
        CAUSE_PERM     = 2'd2,
        CAUSE_BAD_OP   = 2'd3
    } cause_e;

    // Indices of the chips in the legacy fixed decoder, now default table slots.
    typedef enum int {
        CHIP_RAM = 0,
        CHIP_ROM = 1,
        CHIP_IO  = 2,
        CHIP_EXT = 3
    } chip_e;

    localparam logic [2:0] PERM_R = 3'b001;
    localparam logic [2:0] PERM_W = 3'b010;
    localparam logic [2:0] PERM_X = 3'b100;

    typedef struct packed {
        logic [PMA_MAX_ADDR_W-1:0] base;
        logic [PMA_MAX_ADDR_W-1:0] size;
        logic [2:0]                perm;
        logic                      lock;
    } region_t;

    localparam region_t DEFAULT_MAP [PMA_NUM_DEFAULT] = '{
        '{base: 64'h0000_0000, size: 64'h0000_1000, perm: PERM_R | PERM_W,          lock: 1'b0},
        '{base: 64'h0000_1000, size: 64'h000f_f000, perm: PERM_R | PERM_X,          lock: 1'b0},
        '{base: 64'h1000_0000, size: 64'h0000_0100, perm: PERM_R | PERM_W,          lock: 1'b0},
        '{base: 64'h8000_0000, size: 64'h8000_0000, perm: PERM_R | PERM_W | PERM_X, lock: 1'b0}
    };

    function automatic region_t default_entry(input int idx);
        if (idx >= 0 && idx < PMA_NUM_DEFAULT) begin
            return DEFAULT_MAP[idx[1:0]];
        end
        return '0;
    endfunction

    function automatic logic [2:0] op_perm(input logic [1:0] op);
        case (op_e'(op))
            OP_READ:  return PERM_R;
            OP_WRITE: return PERM_W;
            OP_FETCH: return PERM_X;
            default:  return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/pma_region_match.sv
// Combinational hit and permission test of one address against one region entry.
module pma_region_match
    import pma_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] size,
    input  logic [2:0]        perm,
    output logic              hit,
    output logic              perm_ok
);

    logic [ADDR_W-1:0] offset;

    // Offset compare instead of base+size so a region ending at 2^ADDR_W never wraps.
    assign offset  = addr - base;
    assign hit     = (size != '0) && (addr >= base) && (offset < size);
    assign perm_ok = (perm & op_perm(op)) != 3'b000;

endmodule

// File: rtl/pma_router.sv
// Programmable region decoder: one registered valid/ready stage that returns the
// region index, region-relative offset and fault verdict for each request.
module pma_router
    import pma_pkg::*;
#(
    parameter  int NUM_REGIONS = 4,
    parameter  int ADDR_W      = 64,
    parameter  int CNT_W       = 32,
    localparam int IDX_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDX_W-1:0]  rsp_idx,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_err,
    output logic [1:0]        rsp_cause,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_size,
    input  logic [2:0]        cfg_perm,
    input  logic              cfg_lock,
    output logic              cfg_err,
    output logic [CNT_W-1:0]  fault_cnt
);

    logic [ADDR_W-1:0] base_q [NUM_REGIONS];
    logic [ADDR_W-1:0] base_d [NUM_REGIONS];
    logic [ADDR_W-1:0] size_q [NUM_REGIONS];
    logic [ADDR_W-1:0] size_d [NUM_REGIONS];
    logic [2:0]        perm_q [NUM_REGIONS];
    logic [2:0]        perm_d [NUM_REGIONS];
    logic              lock_q [NUM_REGIONS];
    logic              lock_d [NUM_REGIONS];

    logic              rsp_valid_q, rsp_valid_d;
    logic [IDX_W-1:0]  rsp_idx_q, rsp_idx_d;
    logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic              rsp_err_q, rsp_err_d;
    logic [1:0]        rsp_cause_q, rsp_cause_d;
    logic              cfg_err_q, cfg_err_d;
    logic [CNT_W-1:0]  fault_cnt_q, fault_cnt_d;

    logic [NUM_REGIONS-1:0] hit;
    logic [NUM_REGIONS-1:0] perm_ok;
    logic                   found;
    logic [IDX_W-1:0]       sel_idx;
    logic [ADDR_W-1:0]      sel_base;
    logic                   sel_perm_ok;
    logic [1:0]             dec_cause;
    logic                   dec_err;
    logic                   accept;

    function automatic logic [ADDR_W-1:0] rst_base(input int i);
        region_t e;
        e = default_entry(i);
        return e.base[ADDR_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] rst_size(input int i);
        region_t e;
        e = default_entry(i);
        return e.size[ADDR_W-1:0];
    endfunction

    function automatic logic [2:0] rst_perm(input int i);
        region_t e;
        e = default_entry(i);
        return e.perm;
    endfunction

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_match
        pma_region_match #(
            .ADDR_W (ADDR_W)
        ) u_match (
            .addr    (req_addr),
            .op      (req_op),
            .base    (base_q[g]),
            .size    (size_q[g]),
            .perm    (perm_q[g]),
            .hit     (hit[g]),
            .perm_ok (perm_ok[g])
        );
    end

    // Lowest hitting index wins when regions overlap.
    always_comb begin
        found       = 1'b0;
        sel_idx     = '0;
        sel_base    = '0;
        sel_perm_ok = 1'b0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (!found && hit[i]) begin
                found       = 1'b1;
                sel_idx     = IDX_W'(i);
                sel_base    = base_q[i];
                sel_perm_ok = perm_ok[i];
            end
        end
    end

    always_comb begin
        dec_cause = CAUSE_NONE;
        if (req_op == OP_RSVD) begin
            dec_cause = CAUSE_BAD_OP;
        end else if (!found) begin
            dec_cause = CAUSE_UNMAPPED;
        end else if (!sel_perm_ok) begin
            dec_cause = CAUSE_PERM;
        end
    end

    assign dec_err   = (dec_cause != CAUSE_NONE);
    assign req_ready = !rsp_valid_q || rsp_ready;
    assign accept    = req_valid && req_ready;

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_idx_d   = rsp_idx_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_err_d   = rsp_err_q;
        rsp_cause_d = rsp_cause_q;
        fault_cnt_d = fault_cnt_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = dec_err;
            rsp_cause_d = dec_cause;
            rsp_idx_d   = dec_err ? '0 : sel_idx;
            rsp_addr_d  = dec_err ? req_addr : (req_addr - sel_base);
            if (dec_err && (fault_cnt_q != {CNT_W{1'b1}})) begin
                fault_cnt_d = fault_cnt_q + CNT_W'(1);
            end
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Table updates land at the edge, so a same-cycle request still sees the old entry.
    always_comb begin
        cfg_err_d = 1'b0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            base_d[i] = base_q[i];
            size_d[i] = size_q[i];
            perm_d[i] = perm_q[i];
            lock_d[i] = lock_q[i];
            if (cfg_we && (cfg_idx == IDX_W'(i))) begin
                if (lock_q[i]) begin
                    cfg_err_d = 1'b1;
                end else begin
                    base_d[i] = cfg_base;
                    size_d[i] = cfg_size;
                    perm_d[i] = cfg_perm;
                    lock_d[i] = cfg_lock;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_addr_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_cause_q <= '0;
            cfg_err_q   <= 1'b0;
            fault_cnt_q <= '0;
            for (int i = 0; i < NUM_REGIONS; i++) begin
                base_q[i] <= rst_base(i);
                size_q[i] <= rst_size(i);
                perm_q[i] <= rst_perm(i);
                lock_q[i] <= 1'b0;
            end
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_idx_q   <= rsp_idx_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_err_q   <= rsp_err_d;
            rsp_cause_q <= rsp_cause_d;
            cfg_err_q   <= cfg_err_d;
            fault_cnt_q <= fault_cnt_d;
            for (int i = 0; i < NUM_REGIONS; i++) begin
                base_q[i] <= base_d[i];
                size_q[i] <= size_d[i];
                perm_q[i] <= perm_d[i];
                lock_q[i] <= lock_d[i];
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_idx   = rsp_idx_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_cause = rsp_cause_q;
    assign cfg_err   = cfg_err_q;
    assign fault_cnt = fault_cnt_q;

endmodule
